// File: rtl/key_schedule_seq_pkg.sv
// Shared definitions for the sequential AES key-schedule engine.
package key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    KL_128     = 2'd0,
    KL_192     = 2'd1,
    KL_256     = 2'd2,
    KL_ILLEGAL = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } state_t;

  // Nk: key length in 32-bit words.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  // Nr: number of rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return nk_of(kl) + 4'd6;
  endfunction

  // Total schedule length in words: 4*(Nr+1).
  function automatic logic [5:0] words_of(input logic [1:0] kl);
    return {nr_of(kl), 2'b00} + 6'd4;
  endfunction

  // Key length in bits for a key_len code.
  function automatic int unsigned key_bits_of(input logic [1:0] kl);
    return 32'd128 + 32'(kl) * 32'd64;
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotate of a word by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_schedule_seq_sbox.sv
// key_sbox_word: four parallel combinational AES S-box byte lookups.
module key_sbox_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte-wise substitution of the whole word.
  always_comb begin
    o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
              SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion: one schedule word per clock into a
// round-key store, with registered round-key read-back.
module key_schedule_seq
  import key_schedule_seq_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         err,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int unsigned MAX_NR = MAX_KEY_BITS / 32 + 6;
  localparam int unsigned WORDS  = 4 * (MAX_NR + 1);

  state_t        r_state, w_next;
  logic [1:0]    r_klen;
  logic [255:0]  r_key;
  logic [5:0]    r_idx;
  logic [3:0]    r_kcnt;
  logic [7:0]    r_rcon;
  logic [31:0]   r_win [8];
  logic          r_ready, r_err;
  logic [127:0]  r_rd_key;
  logic [31:0]   r_mem [WORDS];

  logic          w_accept, w_reject, w_len_ok, w_active;
  logic [3:0]    w_nk;
  logic [5:0]    w_words, w_rd_base;
  logic [2:0]    w_far_sel;
  logic [31:0]   w_sb_in, w_sb_out, w_temp, w_word;
  logic          w_rd_ok;

  assign w_nk      = nk_of(r_klen);
  assign w_words   = words_of(r_klen);
  assign w_len_ok  = (key_len != KL_ILLEGAL) && (key_bits_of(key_len) <= MAX_KEY_BITS);
  assign w_active  = (r_state == ST_LOAD) || (r_state == ST_EXPAND);
  // Window slot Nk-1 holds w[i-Nk]; Nk=8 wraps to slot 7.
  assign w_far_sel = w_nk[2:0] - 3'd1;

  key_sbox_word u_sbox (
    .i_word (w_sb_in),
    .o_word (w_sb_out)
  );

  // Word generator: key words during LOAD, expansion rule during EXPAND.
  always_comb begin
    w_sb_in = (r_kcnt == 4'd0) ? rot_word(r_win[0]) : r_win[0];
    w_temp  = r_win[0];
    if (r_kcnt == 4'd0)
      w_temp = w_sb_out ^ {r_rcon, 24'h0};
    else if ((w_nk == 4'd8) && (r_kcnt == 4'd4))
      w_temp = w_sb_out;
    w_word = (r_state == ST_LOAD) ? r_key[255:224] : (r_win[w_far_sel] ^ w_temp);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and start acceptance/rejection.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_accept = 1'b1;
            w_next   = ST_LOAD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_LOAD:   if (r_idx == {2'b00, w_nk} - 6'd1) w_next = ST_EXPAND;
      ST_EXPAND: if (r_idx == w_words - 6'd1)       w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Datapath: key shifter, word index, Nk-phase counter, rcon, window, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen   <= '0;
      r_key    <= '0;
      r_idx    <= '0;
      r_kcnt   <= '0;
      r_rcon   <= '0;
      for (int unsigned k = 0; k < 8; k++) r_win[k] <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_rd_key <= '0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_klen  <= key_len;
        r_key   <= key;
        r_idx   <= '0;
        r_kcnt  <= '0;
        r_rcon  <= 8'h01;
        r_ready <= 1'b0;
      end
      if (w_active) begin
        r_win[0] <= w_word;
        for (int unsigned k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
        r_idx  <= r_idx + 6'd1;
        r_kcnt <= (r_kcnt == w_nk - 4'd1) ? 4'd0 : r_kcnt + 4'd1;
        if (r_state == ST_LOAD) r_key <= r_key << 32;
        if ((r_state == ST_EXPAND) && (r_kcnt == 4'd0)) r_rcon <= xtime(r_rcon);
      end
      if ((r_state == ST_EXPAND) && (w_next == ST_DONE)) r_ready <= 1'b1;
      r_rd_key <= w_rd_ok ? {r_mem[w_rd_base],         r_mem[w_rd_base + 6'd1],
                             r_mem[w_rd_base + 6'd2],  r_mem[w_rd_base + 6'd3]} : '0;
    end
  end

  assign w_rd_base = {rd_round, 2'b00};
  assign w_rd_ok   = r_ready && (rd_round <= nr_of(r_klen));

  // Round-key store write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_active) r_mem[r_idx] <= w_word;
  end

  assign busy   = w_active;
  assign done   = (r_state == ST_DONE);
  assign ready  = r_ready;
  assign err    = r_err;
  assign rd_key = r_rd_key;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Randomised self-checking bench for key_schedule_seq against a
// FIPS-197 style key-expansion model with a computed S-box.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst, start, start128;
  logic [1:0]   key_len, key_len128;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         busy, done, ready, err;
  logic [127:0] rd_key;
  logic         busy128, done128, ready128, err128;
  logic [127:0] rd_key128;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  m_sbox [256];
  logic [31:0] mw [60];
  int          m_nr;

  always #5 clk = ~clk;

  key_schedule_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .ready(ready), .err(err),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  key_schedule_seq #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .key_len(key_len128), .key(key),
    .busy(busy128), .done(done128), .ready(ready128), .err(err128),
    .rd_round(rd_round), .rd_key(rd_key128)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      m_sbox[a] = s;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
  endfunction

  function automatic void model_expand(input int kl, input logic [255:0] k);
    int nk = 4 + 2 * kl;
    int total;
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    m_nr  = nk + 6;
    total = 4 * (m_nr + 1);
    for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endfunction

  function automatic logic [127:0] exp_round(input int r);
    if (r > m_nr) return '0;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic read_all(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_round = 4'(r);
      tick();
      check_eq($sformatf("%s_rd%0d", tag, r), rd_key, exp_round(r));
    end
  endtask

  // Run one expansion; poke >= 0 raises start for one cycle mid-expansion.
  task automatic run_schedule(input int kl, input logic [255:0] k, input string tag, input int poke);
    int cyc = 0;
    int busy_low = 0;
    int err_seen = 0;
    logic done_seen = 1'b0;
    logic rdy_at_done = 1'b0;
    model_expand(kl, k);
    key_len = 2'(kl);
    key     = k;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    while (cyc < 100 && !done_seen) begin
      if (cyc == poke) begin
        start   = 1'b1;
        key     = rand256();
        key_len = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (done) begin
        done_seen   = 1'b1;
        rdy_at_done = ready;
      end else if (!busy) begin
        busy_low++;
      end
      if (err) err_seen++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 128'(done_seen), 128'd1);
    check_eq({tag, "_cycles"}, 128'(cyc), 128'(4 * (m_nr + 1)));
    check_eq({tag, "_ready_with_done"}, 128'(rdy_at_done), 128'd1);
    check_eq({tag, "_busy_gap"}, 128'(busy_low), 128'd0);
    check_eq({tag, "_err_while_busy"}, 128'(err_seen), 128'd0);
    tick();
    check_eq({tag, "_done_one_cycle"}, 128'(done), 128'd0);
    read_all(tag);
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    build_sbox();
    rst = 1'b1; start = 1'b0; start128 = 1'b0;
    key_len = 2'd0; key_len128 = 2'd0; key = '0; rd_round = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rst_busy",  128'(busy),  128'd0);
    check_eq("rst_done",  128'(done),  128'd0);
    check_eq("rst_ready", 128'(ready), 128'd0);
    check_eq("rst_err",   128'(err),   128'd0);
    check_eq("rst_rdkey", rd_key,      128'd0);

    // Narrow instance rejects AES-256.
    key_len128 = 2'd2;
    start128   = 1'b1;
    tick();
    start128   = 1'b0;
    check_eq("max128_err",  128'(err128),  128'd1);
    check_eq("max128_busy", 128'(busy128), 128'd0);
    tick();
    check_eq("max128_err_pulse", 128'(err128), 128'd0);

    // Known-answer vectors.
    run_schedule(0, K128, "kat128", -1);
    rd_round = 4'd10; tick();
    check_eq("kat128_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_schedule(2, K256, "kat256", 7);
    rd_round = 4'd14; tick();
    check_eq("kat256_r14", rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
    run_schedule(1, K192, "kat192", -1);
    rd_round = 4'd12; tick();
    check_eq("kat192_r12", rd_key, 128'he98ba06f448c773c8ecc720401002202);

    // Illegal key_len leaves the stored schedule intact.
    key_len = 2'd3; key = rand256(); start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("illegal_err",  128'(err),  128'd1);
    check_eq("illegal_busy", 128'(busy), 128'd0);
    tick();
    check_eq("illegal_err_pulse", 128'(err),   128'd0);
    check_eq("illegal_ready",     128'(ready), 128'd1);
    read_all("illegal_keep");

    // Reset in the middle of an AES-256 expansion, then restart.
    model_expand(2, K256);
    key_len = 2'd2; key = K256; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_busy",  128'(busy),  128'd0);
    check_eq("midrst_ready", 128'(ready), 128'd0);
    check_eq("midrst_rdkey", rd_key,      128'd0);
    rst = 1'b0;
    tick();
    run_schedule(0, K128, "after_rst128", -1);
    rd_round = 4'd10; tick();
    check_eq("after_rst128_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys and lengths; unused key LSBs carry random junk.
    for (int n = 0; n < 8; n++) begin
      int kl = $urandom_range(0, 2);
      int pk = (n % 2 == 0) ? $urandom_range(0, 40) : -1;
      run_schedule(kl, rand256(), $sformatf("rnd%0d_kl%0d", n, kl), pk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
